sseg_scan_driver: RTL and testbench



---
 rtl/sseg_pkg.sv | 14 +
 rtl/hex_to_sseg.sv | 30 +++
 rtl/sseg_scan_driver.sv | 114 +++++++++++
 tb/tb_sseg_scan_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display peripheral.
package sseg_pkg;

    localparam logic [31:0] DEF_DATA_ADDR = 32'h1100C010;
    localparam logic [31:0] DEF_CTRL_ADDR = 32'h1100C014;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_LZB    = 1;
    localparam int CTRL_DP_LSB = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [7:0] sseg_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low seven-segment pattern, seg[0]=A .. seg[6]=G.
module hex_to_sseg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// IOBUS slave holding a 16-bit display value and control byte; scans the
// four digits autonomously with registered, active-low segment/anode outputs.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR   = DEF_DATA_ADDR,
    parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter int          REFRESH_CNT = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output sseg_t       segs,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

    logic [15:0]      data_reg;
    logic [7:0]       ctrl_reg;
    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;

    logic             hit_data;
    logic             hit_ctrl;
    logic             scan_en;
    logic [3:0]       dp;
    logic [3:0]       nibble;
    logic [6:0]       seg_raw;
    logic             blank;
    sseg_t            segs_nxt;
    logic [3:0]       an_nxt;
    logic             unused_bits;

    assign unused_bits = ^IOBUS_OUT[31:16];

    assign hit_data = (IOBUS_ADDR == DATA_ADDR);
    assign hit_ctrl = (IOBUS_ADDR == CTRL_ADDR);
    assign rd_hit   = hit_data | hit_ctrl;

    always_comb begin
        rd_data = '0;
        if (hit_data)
            rd_data = {16'b0, data_reg};
        else if (hit_ctrl)
            rd_data = {24'b0, ctrl_reg};
    end

    assign scan_en = ctrl_reg[CTRL_EN];
    assign dp      = ctrl_reg[CTRL_DP_LSB +: 4];
    assign nibble  = data_reg[{idx, 2'b00} +: 4];

    hex_to_sseg u_hex (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    // A digit is blanked only when it and every more-significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        if (ctrl_reg[CTRL_LZB]) begin
            case (idx)
                2'd3:    blank = (data_reg[15:12] == 4'h0);
                2'd2:    blank = (data_reg[15:8]  == 8'h00);
                2'd1:    blank = (data_reg[15:4]  == 12'h000);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        an_nxt   = 4'hF;
        segs_nxt = 8'hFF;
        if (scan_en && !blank) begin
            an_nxt   = ~(4'b0001 << idx);
            segs_nxt = {~dp[idx], seg_raw};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_reg <= '0;
            ctrl_reg <= '0;
            cnt      <= '0;
            idx      <= '0;
            an       <= 4'hF;
            segs     <= 8'hFF;
        end else begin
            if (IOBUS_WR && hit_data)
                data_reg <= IOBUS_OUT[15:0];
            if (IOBUS_WR && hit_ctrl)
                ctrl_reg <= IOBUS_OUT[7:0];

            if (!scan_en) begin
                cnt <= '0;
                idx <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            an   <= an_nxt;
            segs <= segs_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: behavioural display model checked every cycle,
// directed literal checks, then randomized register traffic.
module tb_sseg_scan_driver;

    localparam int R = 4;
    localparam logic [31:0] A_DATA = 32'h1100C010;
    localparam logic [31:0] A_CTRL = 32'h1100C014;
    localparam logic [31:0] A_OTHER = 32'h1100C000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [7:0]  segs;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    sseg_scan_driver #(.REFRESH_CNT(R)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .segs       (segs),
        .an         (an)
    );

    always #5 CLK = ~CLK;

    // Model state: register contents, enabled-cycle count, expected outputs.
    logic [7:0]  tab [16];
    logic [15:0] m_data;
    logic [7:0]  m_ctrl;
    int          m_t;
    logic [3:0]  exp_an;
    logic [7:0]  exp_segs;
    int          mi, lead, nib;
    bit          old_en;

    initial begin
        tab[0]  = 8'hC0; tab[1]  = 8'hF9; tab[2]  = 8'hA4; tab[3]  = 8'hB0;
        tab[4]  = 8'h99; tab[5]  = 8'h92; tab[6]  = 8'h82; tab[7]  = 8'hF8;
        tab[8]  = 8'h80; tab[9]  = 8'h90; tab[10] = 8'h88; tab[11] = 8'h83;
        tab[12] = 8'hC6; tab[13] = 8'hA1; tab[14] = 8'h86; tab[15] = 8'h8E;
    end

    always @(posedge CLK) begin
        if (RESET) begin
            m_data   = 16'h0;
            m_ctrl   = 8'h0;
            m_t      = 0;
            exp_an   = 4'hF;
            exp_segs = 8'hFF;
        end else begin
            mi   = (m_t / R) % 4;
            lead = 0;
            for (int k = 0; k < 4; k++)
                if (((m_data >> (4 * k)) & 16'hF) != 0) lead = k;
            nib = int'((m_data >> (4 * mi)) & 16'hF);
            if (!m_ctrl[0] || (m_ctrl[1] && mi > lead)) begin
                exp_an   = 4'hF;
                exp_segs = 8'hFF;
            end else begin
                exp_an     = 4'hF;
                exp_an[mi] = 1'b0;
                exp_segs   = tab[nib];
                exp_segs[7] = ~m_ctrl[4 + mi];
            end
            old_en = m_ctrl[0];
            m_t = old_en ? (m_t + 1) % (4 * R) : 0;
            if (IOBUS_WR && IOBUS_ADDR == A_DATA) m_data = IOBUS_OUT[15:0];
            if (IOBUS_WR && IOBUS_ADDR == A_CTRL) m_ctrl = IOBUS_OUT[7:0];
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            tests++;
            if (an !== exp_an || segs !== exp_segs) begin
                fails++;
                $display("FAIL model_cmp t=%0t an=%h exp=%h segs=%h exp=%h",
                         $time, an, exp_an, segs, exp_segs);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] ea, input logic [7:0] es);
        tests++;
        if (an !== ea || segs !== es) begin
            fails++;
            $display("FAIL %s an=%h exp=%h segs=%h exp=%h", name, an, ea, segs, es);
        end
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] ed, input logic eh);
        IOBUS_ADDR = a;
        #1;
        tests++;
        if (rd_data !== ed || rd_hit !== eh) begin
            fails++;
            $display("FAIL %s addr=%h rd_data=%h exp=%h rd_hit=%b exp=%b",
                     name, a, rd_data, ed, rd_hit, eh);
        end
    endtask

    logic [31:0] ra;
    int op;

    initial begin
        RESET = 1'b1; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
        tick(2);
        chk_en = 1;
        RESET = 1'b0;
        tick(20);
        chk("idle_blank", 4'hF, 8'hFF);
        rd_chk("rd_data_rst", A_DATA, 32'h0, 1'b1);
        rd_chk("rd_ctrl_rst", A_CTRL, 32'h0, 1'b1);
        rd_chk("rd_other", A_OTHER, 32'h0, 1'b0);

        // Basic scan of 0x12AF
        tick();
        wr(A_DATA, 32'hDEAD12AF);
        wr(A_CTRL, 32'h01);
        rd_chk("rd_data_12af", A_DATA, 32'h0000_12AF, 1'b1);
        tick();     chk("scan_d0", 4'hE, 8'h8E);
        tick(R);    chk("scan_d1", 4'hD, 8'h88);
        tick(R);    chk("scan_d2", 4'hB, 8'hA4);
        tick(R);    chk("scan_d3", 4'h7, 8'hF9);
        tick(R);    chk("scan_wrap", 4'hE, 8'h8E);

        // Leading-zero blanking
        wr(A_CTRL, 32'h00);
        wr(A_DATA, 32'h0005);
        wr(A_CTRL, 32'h03);
        tick();     chk("lzb_d0", 4'hE, 8'h92);
        tick(R);    chk("lzb_d1", 4'hF, 8'hFF);
        tick(R);    chk("lzb_d2", 4'hF, 8'hFF);
        tick(R);    chk("lzb_d3", 4'hF, 8'hFF);
        rd_chk("rd_ctrl_03", A_CTRL, 32'h03, 1'b1);

        // Decimal point on digit 1
        wr(A_CTRL, 32'h00);
        wr(A_DATA, 32'h0000);
        wr(A_CTRL, 32'h21);
        tick();     chk("dp_d0", 4'hE, 8'hC0);
        tick(R);    chk("dp_d1", 4'hD, 8'h40);
        tick(R);    chk("dp_d2", 4'hB, 8'hC0);

        // Disable mid-slot at idx 2, then re-enable
        wr(A_CTRL, 32'h00);
        wr(A_CTRL, 32'h01);
        tick(9);    chk("mid_idx2", 4'hB, 8'hC0);
        wr(A_CTRL, 32'h00);
        chk("dis_edge", 4'hB, 8'hC0);
        tick();     chk("dis_blank", 4'hF, 8'hFF);
        wr(A_CTRL, 32'h01);
        tick();     chk("reen_d0", 4'hE, 8'hC0);
        tick(3);    chk("reen_d0_end", 4'hE, 8'hC0);
        tick();     chk("reen_d1", 4'hD, 8'hC0);

        // Reset beats a simultaneous write
        wr(A_DATA, 32'h1234);
        tick(3);
        RESET = 1'b1; IOBUS_ADDR = A_DATA; IOBUS_OUT = 32'hFFFF; IOBUS_WR = 1'b1;
        tick();
        RESET = 1'b0; IOBUS_WR = 1'b0;
        rd_chk("rst_vs_wr_data", A_DATA, 32'h0, 1'b1);
        rd_chk("rst_vs_wr_ctrl", A_CTRL, 32'h0, 1'b1);
        chk("rst_blank", 4'hF, 8'hFF);
        tick();     chk("rst_blank2", 4'hF, 8'hFF);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: tick($urandom_range(1, 10));
                3, 4:    wr(A_DATA, $urandom);
                5:       wr(A_CTRL, {$urandom} | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0));
                6:       wr(A_OTHER + 32'(4 * $urandom_range(0, 3)), $urandom);
                7, 8: begin
                    ra = ($urandom_range(0, 2) == 0) ? A_DATA :
                         ($urandom_range(0, 1) == 0) ? A_CTRL : $urandom;
                    if (ra == A_DATA)
                        rd_chk("rnd_rd_data", ra, {16'h0, m_data}, 1'b1);
                    else if (ra == A_CTRL)
                        rd_chk("rnd_rd_ctrl", ra, {24'h0, m_ctrl}, 1'b1);
                    else
                        rd_chk("rnd_rd_other", ra, 32'h0, 1'b0);
                    tick();
                end
                default: begin
                    if ($urandom_range(0, 4) == 0) begin
                        RESET = 1'b1;
                        tick();
                        RESET = 1'b0;
                    end else begin
                        tick();
                    end
                end
            endcase
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
